// File: rtl/memory_access_stage_pkg.sv
// -----------------------------------------------------------------------------
// memory_access_stage_pkg
// Shared definitions for the MEM pipeline stage and its wait timer:
//   - mem_state_e      : access FSM encoding (IDLE / BUSY)
//   - BAD_DATA_DEFAULT : load value returned on abort or misaligned load
//   - TIMER_W          : width of the BUSY wait counter
//   - is_misaligned()  : word-alignment check for a data-memory access
// -----------------------------------------------------------------------------
package memory_access_stage_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  localparam logic [31:0] BAD_DATA_DEFAULT = 32'h0;

  // Wide enough for any TIMEOUT in 1..255.
  localparam int unsigned TIMER_W = 8;

  // Data memory is word addressed; any access with low address bits set
  // cannot be serviced.
  function automatic logic is_misaligned(input logic access, input logic [31:0] addr);
    return access & (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/memory_access_stage_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Wait-cycle counter for a memory handshake. Counts cycles spent waiting on a
// slave and flags when the configured limit has been reached.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   clr       : force count to 0 (highest priority)
//   start     : load count with 1 (first wait cycle of a new access)
//   inc       : increment count
//   limit     : wait limit
//   expired   : count has reached limit
// -----------------------------------------------------------------------------
module mem_wait_timer
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (start) begin
      count_d = W'(1);
    end else if (inc) begin
      count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its input from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // >= rather than == keeps the flag safe if limit is ever lowered mid-wait.
  assign expired = (count_q >= limit);

endmodule

// File: rtl/memory_access_stage.sv
// -----------------------------------------------------------------------------
// memory_access_stage
// MEM stage of the 5-stage MIPS pipeline. Consumes the XM_* register from
// execute, performs lw/sw over a variable-latency req/ready data-memory
// handshake, and produces the MW_* register for write-back.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   XM_MemtoReg/RegWrite/MemRead/MemWrite/branch : control from execute
//   ALUout, XM_MD, XM_RD, XM_BT  : address/result, store data, dest, branch target
//   dm_rdata, dm_ready           : memory read data and completion strobe
//   dm_req, dm_we, dm_addr, dm_wdata : memory request
//   mem_stall                    : freeze XM register and earlier stages
//   branch_taken, branch_target  : resolved branch toward fetch
//   MW_MemtoReg, MW_RegWrite, MW_ALUout, MW_MemData, MW_RD : to write-back
//   mem_err                      : sticky error (timeout or misalignment)
// Parameters:
//   TIMEOUT  : max BUSY wait cycles before abort (1..255)
//   BAD_DATA : load result on abort or misaligned load
// -----------------------------------------------------------------------------
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] BAD_DATA = BAD_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        XM_MemtoReg,
  input  logic        XM_RegWrite,
  input  logic        XM_MemRead,
  input  logic        XM_MemWrite,
  input  logic        XM_branch,
  input  logic [31:0] ALUout,
  input  logic [31:0] XM_MD,
  input  logic [4:0]  XM_RD,
  input  logic [31:0] XM_BT,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ready,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        mem_stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        MW_MemtoReg,
  output logic        MW_RegWrite,
  output logic [31:0] MW_ALUout,
  output logic [31:0] MW_MemData,
  output logic [4:0]  MW_RD,
  output logic        mem_err
);

  localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);

  mem_state_e  state_q, state_d;

  logic        mw_memtoreg_q, mw_memtoreg_d;
  logic        mw_regwrite_q, mw_regwrite_d;
  logic [31:0] mw_aluout_q,   mw_aluout_d;
  logic [31:0] mw_memdata_q,  mw_memdata_d;
  logic [4:0]  mw_rd_q,       mw_rd_d;
  logic        mem_err_q,     mem_err_d;

  logic access;
  logic misaligned;
  logic req_raw;
  logic stall_raw;
  logic abort;
  logic timer_clr;
  logic timer_start;
  logic timer_inc;
  logic timer_expired;

  assign access     = XM_MemRead | XM_MemWrite;
  assign misaligned = is_misaligned(access, ALUout);

  // ---------------------------------------------------------------------------
  // Access FSM: next state, request, stall and timer control.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    req_raw     = 1'b0;
    stall_raw   = 1'b0;
    abort       = 1'b0;
    timer_clr   = 1'b0;
    timer_start = 1'b0;
    timer_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (access && !misaligned) begin
          req_raw = 1'b1;
          // Same-cycle dm_ready is a zero-wait completion; otherwise wait.
          if (!dm_ready) begin
            stall_raw   = 1'b1;
            state_d     = ST_BUSY;
            timer_start = 1'b1;
          end
        end
      end

      ST_BUSY: begin
        // Upstream is frozen, so address/we/wdata stay stable while waiting.
        req_raw = 1'b1;
        if (dm_ready) begin
          state_d   = ST_IDLE;
          timer_clr = 1'b1;
        end else if (timer_expired) begin
          // Request is still visible this cycle; the memory drops it since
          // it was not acknowledged before the edge.
          abort     = 1'b1;
          state_d   = ST_IDLE;
          timer_clr = 1'b1;
        end else begin
          stall_raw = 1'b1;
          timer_inc = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request and stall fall away as soon as reset asserts, even though the
  // XM inputs may still describe a memory instruction.
  assign dm_req    = req_raw & ~rst;
  assign mem_stall = stall_raw & ~rst;

  assign dm_we    = XM_MemWrite;
  assign dm_addr  = ALUout;
  assign dm_wdata = XM_MD;

  assign branch_taken  = XM_branch;
  assign branch_target = XM_BT;

  mem_wait_timer #(
    .W (TIMER_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .start   (timer_start),
    .inc     (timer_inc),
    .limit   (TIMEOUT_C),
    .expired (timer_expired)
  );

  // ---------------------------------------------------------------------------
  // MW pipeline register.
  // ---------------------------------------------------------------------------
  always_comb begin
    mw_memtoreg_d = mw_memtoreg_q;
    mw_regwrite_d = mw_regwrite_q;
    mw_aluout_d   = mw_aluout_q;
    mw_memdata_d  = mw_memdata_q;
    mw_rd_d       = mw_rd_q;

    if (stall_raw) begin
      // Bubble: nothing may be written back while the access is pending.
      mw_memtoreg_d = 1'b0;
      mw_regwrite_d = 1'b0;
    end else begin
      mw_memtoreg_d = XM_MemtoReg;
      mw_regwrite_d = XM_RegWrite;
      mw_aluout_d   = ALUout;
      mw_rd_d       = XM_RD;
      if (XM_MemRead) begin
        mw_memdata_d = (misaligned || abort) ? BAD_DATA : dm_rdata;
      end
    end
  end

  assign mem_err_d = mem_err_q | misaligned | abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      mw_memtoreg_q <= 1'b0;
      mw_regwrite_q <= 1'b0;
      mw_aluout_q   <= '0;
      mw_memdata_q  <= '0;
      mw_rd_q       <= '0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mw_memtoreg_q <= mw_memtoreg_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_aluout_q   <= mw_aluout_d;
      mw_memdata_q  <= mw_memdata_d;
      mw_rd_q       <= mw_rd_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign MW_MemtoReg = mw_memtoreg_q;
  assign MW_RegWrite = mw_regwrite_q;
  assign MW_ALUout   = mw_aluout_q;
  assign MW_MemData  = mw_memdata_q;
  assign MW_RD       = mw_rd_q;
  assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_access_stage
// Directed bench for memory_access_stage (TIMEOUT=4, non-zero BAD_DATA).
// Inputs change 1 ns after the rising edge; combinational outputs are sampled
// on the falling edge, registered outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_memory_access_stage;

  localparam logic [31:0] BAD = 32'hBAD0_DA7A;

  logic        clk;
  logic        rst;
  logic        XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch;
  logic [31:0] ALUout, XM_MD, XM_BT, dm_rdata;
  logic [4:0]  XM_RD;
  logic        dm_ready;
  logic        dm_req, dm_we, mem_stall, branch_taken;
  logic [31:0] dm_addr, dm_wdata, branch_target;
  logic        MW_MemtoReg, MW_RegWrite, mem_err;
  logic [31:0] MW_ALUout, MW_MemData;
  logic [4:0]  MW_RD;

  int n_checks = 0;
  int n_pass   = 0;

  memory_access_stage #(
    .TIMEOUT  (4),
    .BAD_DATA (BAD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .XM_MemtoReg   (XM_MemtoReg),
    .XM_RegWrite   (XM_RegWrite),
    .XM_MemRead    (XM_MemRead),
    .XM_MemWrite   (XM_MemWrite),
    .XM_branch     (XM_branch),
    .ALUout        (ALUout),
    .XM_MD         (XM_MD),
    .XM_RD         (XM_RD),
    .XM_BT         (XM_BT),
    .dm_rdata      (dm_rdata),
    .dm_ready      (dm_ready),
    .dm_req        (dm_req),
    .dm_we         (dm_we),
    .dm_addr       (dm_addr),
    .dm_wdata      (dm_wdata),
    .mem_stall     (mem_stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .MW_MemtoReg   (MW_MemtoReg),
    .MW_RegWrite   (MW_RegWrite),
    .MW_ALUout     (MW_ALUout),
    .MW_MemData    (MW_MemData),
    .MW_RD         (MW_RD),
    .mem_err       (mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic rd_en, input logic wr_en, input logic m2r,
                       input logic rw, input logic [31:0] addr,
                       input logic [31:0] md, input logic [4:0] rd);
    XM_MemRead  = rd_en;
    XM_MemWrite = wr_en;
    XM_MemtoReg = m2r;
    XM_RegWrite = rw;
    ALUout      = addr;
    XM_MD       = md;
    XM_RD       = rd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dm_ready = 1'b0;
    dm_rdata = 32'h0;
  endtask

  initial begin
    rst       = 1'b0;
    XM_branch = 1'b0;
    XM_BT     = 32'h0;
    idle();
    #1 rst = 1'b1;

    // ---- reset state ----
    mid();
    check("rst_dm_req",    dm_req,      0);
    check("rst_stall",     mem_stall,   0);
    check("rst_mw_rw",     MW_RegWrite, 0);
    check("rst_mw_rd",     MW_RD,       0);
    check("rst_mw_data",   MW_MemData,  0);
    check("rst_mem_err",   mem_err,     0);
    rst = 1'b0;
    tick();

    // ---- branch pass-through ----
    XM_branch = 1'b1;
    XM_BT     = 32'h0000_1000;
    #1;
    check("br_taken",  branch_taken,  1);
    check("br_target", branch_target, 32'h0000_1000);
    XM_branch = 1'b0;
    XM_BT     = 32'h0;

    // ---- zero-wait load ----
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd5);
    dm_ready = 1'b1;
    dm_rdata = 32'h1234_5678;
    mid();
    check("zw_req",   dm_req,    1);
    check("zw_stall", mem_stall, 0);
    check("zw_we",    dm_we,     0);
    check("zw_addr",  dm_addr,   32'h10);
    tick();
    idle();
    check("zw_mw_data", MW_MemData,  32'h1234_5678);
    check("zw_mw_rd",   MW_RD,       5);
    check("zw_mw_rw",   MW_RegWrite, 1);
    check("zw_mw_m2r",  MW_MemtoReg, 1);
    check("zw_mw_alu",  MW_ALUout,   32'h10);

    // ---- 3-cycle load ----
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd7);
    dm_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      mid();
      check($sformatf("l3_stall%0d", i), mem_stall, 1);
      check($sformatf("l3_req%0d", i),   dm_req,    1);
      check($sformatf("l3_addr%0d", i),  dm_addr,   32'h40);
      tick();
      check($sformatf("l3_bubble%0d", i), MW_RegWrite, 0);
      check($sformatf("l3_hold%0d", i),   MW_MemData,  32'h1234_5678);
    end
    dm_ready = 1'b1;
    dm_rdata = 32'hA5A5_0003;
    mid();
    check("l3_release", mem_stall, 0);
    tick();
    idle();
    check("l3_mw_data", MW_MemData,  32'hA5A5_0003);
    check("l3_mw_rd",   MW_RD,       7);
    check("l3_mw_rw",   MW_RegWrite, 1);
    mid();
    check("l3_idle_req", dm_req, 0);
    tick();
    check("l3_data_once", MW_MemData,  32'hA5A5_0003);
    check("l3_idle_rw",   MW_RegWrite, 0);

    // ---- store, one wait cycle ----
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hCAFE_F00D, 5'd0);
    mid();
    check("st_we",    dm_we,     1);
    check("st_wdata", dm_wdata,  32'hCAFE_F00D);
    check("st_stall", mem_stall, 1);
    tick();
    dm_ready = 1'b1;
    mid();
    check("st_release", mem_stall, 0);
    tick();
    idle();
    check("st_mw_rw",   MW_RegWrite, 0);
    check("st_mw_alu",  MW_ALUout,   32'h20);
    check("st_mw_data", MW_MemData,  32'hA5A5_0003);
    check("st_no_err",  mem_err,     0);

    // ---- misaligned load and store ----
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h22, 32'h0, 5'd3);
    dm_ready = 1'b1;
    dm_rdata = 32'h7777_7777;
    mid();
    check("mis_ld_req",   dm_req,    0);
    check("mis_ld_stall", mem_stall, 0);
    check("mis_err_pre",  mem_err,   0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h1111_2222, 5'd0);
    dm_ready = 1'b0;
    check("mis_ld_data", MW_MemData, BAD);
    check("mis_ld_rd",   MW_RD,      3);
    check("mis_err",     mem_err,    1);
    mid();
    check("mis_st_req", dm_req, 0);
    tick();
    idle();
    check("mis_st_data", MW_MemData, BAD);

    // ---- reset in the second wait cycle ----
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 32'h0, 5'd4);
    tick();
    rst = 1'b1;
    #1;
    check("rb_req",     dm_req,      0);
    check("rb_stall",   mem_stall,   0);
    check("rb_mw_rw",   MW_RegWrite, 0);
    check("rb_mw_m2r",  MW_MemtoReg, 0);
    check("rb_mw_alu",  MW_ALUout,   0);
    check("rb_mw_data", MW_MemData,  0);
    check("rb_mw_rd",   MW_RD,       0);
    check("rb_err",     mem_err,     0);
    mid();
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h34, 32'h0, 5'd6);
    dm_ready = 1'b1;
    dm_rdata = 32'h5555_AAAA;
    #1;
    check("ra_stall", mem_stall, 0);
    check("ra_req",   dm_req,    1);
    tick();
    idle();
    check("ra_mw_data", MW_MemData,  32'h5555_AAAA);
    check("ra_mw_rd",   MW_RD,       6);
    check("ra_mw_rw",   MW_RegWrite, 1);

    // ---- timeout (TIMEOUT=4) ----
    drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h80, 32'h0, 5'd9);
    dm_rdata = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      mid();
      check($sformatf("to_stall%0d", i), mem_stall, 1);
      tick();
    end
    mid();
    check("to_release",   mem_stall, 0);
    check("to_req_abort", dm_req,    1);
    check("to_err_pre",   mem_err,   0);
    tick();
    idle();
    check("to_mw_data", MW_MemData,  BAD);
    check("to_mw_rd",   MW_RD,       9);
    check("to_mw_rw",   MW_RegWrite, 1);
    check("to_err",     mem_err,     1);
    tick();
    tick();
    check("to_err_sticky", mem_err, 1);
    check("to_idle_req",   dm_req,  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. It consumes the XM_* pipeline register produced by the execute stage and drives the MW_* pipeline register toward write-back.
- Services lw/sw through a req/ready data-memory handshake with variable latency, stalling upstream while an access is outstanding.
- Also forwards the resolved branch (XM_branch/XM_BT) to fetch.

Parameters:
- TIMEOUT, 64: maximum wait cycles in BUSY before an access is aborted (1..255).
- BAD_DATA, 32'h0: load result returned on abort or misaligned load.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-high
- XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch  in  1 each  control bits from execute
- ALUout  in  32  effective address / ALU result
- XM_MD  in  32  store data
- XM_RD  in  5  destination register
- XM_BT  in  32  branch target
- dm_rdata  in  32  memory read data, valid when dm_ready=1
- dm_ready  in  1  memory completes the current request this cycle
- dm_req  out  1  request valid
- dm_we  out  1  1=store, 0=load
- dm_addr  out  32  word address (= ALUout)
- dm_wdata  out  32  store data (= XM_MD)
- mem_stall  out  1  upstream must hold the XM register and earlier stages
- branch_taken  out  1  = XM_branch (combinational)
- branch_target  out  32  = XM_BT (combinational)
- MW_MemtoReg, MW_RegWrite  out  1 each  registered control
- MW_ALUout  out  32  registered ALU result
- MW_MemData  out  32  registered load data
- MW_RD  out  5  registered destination
- mem_err  out  1  sticky error flag (timeout or misalignment)

Behaviour:
- Reset (async): state=IDLE, wait counter=0, all MW_* outputs=0, mem_err=0. dm_req drops immediately.
- access = XM_MemRead | XM_MemWrite. misaligned = access & (ALUout[1:0] != 0).
- Misaligned access:
  - No request is issued and there is no stall.
  - A load completes with MW_MemData=BAD_DATA.
  - A store is dropped.
  - mem_err is set at the next edge.
- IDLE:
  - dm_req = access & !misaligned.
  - If a request is issued and dm_ready=1 in the same cycle, it is a zero-wait completion: no stall, MW captures at this edge, state stays IDLE.
  - If a request is issued and dm_ready=0: mem_stall=1, next state=BUSY, counter=1.
- BUSY:
  - dm_req=1; dm_addr, dm_we and dm_wdata are stable because upstream is frozen.
  - dm_ready=1: mem_stall=0, MW captures (MW_MemData=dm_rdata for a load), next state=IDLE.
  - dm_ready=0 and counter==TIMEOUT: abort. dm_req is still high this cycle; the memory must ignore a request that is not acknowledged by that cycle's end. mem_stall=0, load data=BAD_DATA, mem_err set, next state=IDLE.
  - Otherwise: mem_stall=1, counter increments.
- mem_stall is combinational: (IDLE & access & !misaligned & !dm_ready) | (BUSY & !dm_ready & counter<TIMEOUT).
- MW register update every edge:
  - If mem_stall=1, a bubble is inserted: MW_RegWrite=0, MW_MemtoReg=0; other MW fields hold.
  - Otherwise MW_* capture XM_* and ALUout. MW_MemData is captured from dm_rdata, or BAD_DATA on abort/misaligned load, or holds for non-loads.
- Store completion never writes the register file (XM_RegWrite=0 is passed through as given).
- branch_taken and branch_target are pure pass-through and are not gated by mem_stall; branch instructions never access memory.
- dm_ready while dm_req=0 is ignored.
- mem_err clears only on rst.

Decomposition:
- Shared package: FSM state encoding (IDLE=1'b0, BUSY=1'b1), BAD_DATA default, and a width constant for the TIMEOUT counter (8 bits).
- One natural sub-module, mem_wait_timer: a counter with clear/enable and an expired output, reused later by the instruction-fetch side.

Test Plan:
- Zero-wait load: MemRead=1, ALUout=0x10, dm_ready=1 with rdata=0x12345678 in the same cycle, RD=5 -> no stall. Next cycle MW_MemData=0x12345678, MW_RD=5, MW_RegWrite=1.
- 3-cycle load: dm_ready rises 3 cycles after the request -> mem_stall high for exactly 3 cycles with MW_RegWrite=0 during them. dm_addr is stable throughout, and load data is captured once.
- Store: MemWrite=1, ALUout=0x20, MD=0xCAFEF00D, ready after 1 cycle -> dm_we=1, dm_wdata=0xCAFEF00D, one stall cycle, MW_RegWrite=0.
- Timeout: TIMEOUT=4, dm_ready held 0 -> stall for 4 cycles, then released. MW_MemData=BAD_DATA, mem_err=1 and sticky.
- Misaligned load: ALUout=0x22 -> dm_req never asserted, no stall, MW_MemData=BAD_DATA, mem_err=1.
- Reset mid-BUSY: assert rst in the 2nd wait cycle -> dm_req and mem_stall drop immediately, all MW_*=0. After release the next load proceeds normally.
